// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply, restoring divide.
// Optional MULDIV_FAST_MUL_EN: multiplies finish in one cycle via a combinational multiplier.
module muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e              state_q;
  logic [2:0]          op_q;
  logic                neg_q;
  logic [XLEN-1:0]     a_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [CntW-1:0]     cnt_q;
  logic [XLEN-1:0]     result_q;

  // Operand decode on the incoming op
  logic            s1, s2, neg_in, div_zero, div_ovf;
  logic [XLEN-1:0] mag1, mag2, special_res;

  always_comb begin
    s1 = rs1_i[XLEN-1] & (op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11));
    s2 = rs2_i[XLEN-1] & (op_i[2] ? ~op_i[0] : (op_i[1:0] <= 2'b01));
    mag1 = s1 ? -rs1_i : rs1_i;
    mag2 = s2 ? -rs2_i : rs2_i;
    // Remainder takes the dividend's sign; everything else the product of signs
    neg_in = (op_i[2] & op_i[1]) ? s1 : (s1 ^ s2);
    div_zero = op_i[2] & (rs2_i == '0);
    div_ovf = op_i[2] & ~op_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_i == '1);
    if (div_zero) special_res = op_i[1] ? rs1_i : '1;
    else          special_res = op_i[1] ? '0 : rs1_i;
  end

  // One iteration of each algorithm
  logic [XLEN:0]     mul_sum, div_tmp, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_tmp  = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_tmp - {1'b0, a_q};
    if (!div_diff[XLEN]) div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else                 div_next = {div_tmp[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  function automatic logic [XLEN-1:0] fix_sel(input logic [2:0] op, input logic neg,
                                               input logic [2*XLEN-1:0] v);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   sel;
    if (op[2]) begin
      sel = op[1] ? v[2*XLEN-1:XLEN] : v[XLEN-1:0];
      return neg ? -sel : sel;
    end
    p = neg ? -v : v;
    return (op[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      neg_q    <= 1'b0;
      a_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (flush_i) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            op_q  <= op_i;
            neg_q <= neg_in;
            a_q   <= op_i[2] ? mag2 : mag1;
            acc_q <= {{XLEN{1'b0}}, op_i[2] ? mag1 : mag2};
            if (div_zero || div_ovf) begin
              result_q <= special_res;
              state_q  <= StDone;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!op_i[2]) begin
              result_q <= fix_sel(op_i, neg_in, fast_prod);
              state_q  <= StDone;
`endif
            end else begin
              cnt_q   <= CntW'(XLEN);
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          acc_q <= op_q[2] ? div_next : mul_next;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) state_q <= StFix;
        end
        StFix: begin
          result_q <= fix_sel(op_q, neg_q, acc_q);
          state_q  <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall_o  = ((state_q == StIdle) & start_i & ~flush_i) |
                    (state_q == StCalc) | (state_q == StFix);
  assign done_o   = (state_q == StDone);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed, table-driven bench for muldiv_seq plus flush / reset / back-to-back sequences.
module tb_muldiv_seq;

`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 34;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic        stall, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .op_i     (op),
    .rs1_i    (rs1),
    .rs2_i    (rs2),
    .flush_i  (flush),
    .stall_o  (stall),
    .done_o   (done),
    .result_o (result)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge (IDLE cycle); start held until done is seen.
  task automatic run_op(input int idx, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int   n;
    logic seen, stall_ok;
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    #1;
    stall_ok = (stall === 1'b1);
    n = 0;
    seen = 1'b0;
    while (n < 100 && !seen) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) begin
        seen = 1'b1;
        if (stall !== 1'b0) stall_ok = 1'b0;
      end else if (stall !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    start = 1'b0;
    check($sformatf("v%0d latency", idx), n, lat);
    check($sformatf("v%0d result", idx), result, exp);
    check($sformatf("v%0d stall", idx), {31'b0, stall_ok}, 32'd1);
    @(negedge clk);
    check($sformatf("v%0d done_pulse", idx), {31'b0, done}, 32'd0);
    check($sformatf("v%0d result_held", idx), result, exp);
  endtask

  initial begin
    int          dones;
    logic [31:0] last;

    vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, ML};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ML};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, ML};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ML};
    vecs[4]  = '{3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, ML};
    vecs[5]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, ML};
    vecs[6]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34};
    vecs[7]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34};
    vecs[8]  = '{3'd5, 32'd100,       32'd7,         32'd14,        34};
    vecs[9]  = '{3'd7, 32'd100,       32'd7,         32'd2,         34};
    vecs[10] = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[11] = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[12] = '{3'd6, 32'd5,         32'd0,         32'd5,         1};
    vecs[13] = '{3'd7, 32'd9,         32'd0,         32'd9,         1};
    vecs[14] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[15] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    vecs[16] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
    vecs[17] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         34};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    #1;
    check("reset stall", {31'b0, stall}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back table
    for (int i = 0; i < 18; i++) begin
      run_op(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // Flush of a DIV at cycle N+10
    last = 32'd1;
    op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush idle stall", {31'b0, stall}, 32'd0);
    check("flush no done", {31'b0, done}, 32'd0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("flush done count", dones, 0);
    check("flush result kept", result, last);
    run_op(100, 3'd5, 32'd100, 32'd7, 32'd14, 34);

    // Asynchronous reset mid-MUL at cycle N+5
    op = 3'd0; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("rst stall", {31'b0, stall}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("rst no done", dones, 0);

    run_op(101, 3'd0, 32'd3, 32'd5, 32'd15, ML);
    run_op(102, 3'd7, 32'd17, 32'd5, 32'd2, 34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
